// File: rtl/sram_mem_ctrl.sv
// Word-to-halfword controller between the MEM stage and a 256Kx16 external SRAM.
// Optional access counters (rd_count/wr_count) are built when SRAM_ACCESS_CNT_EN is defined.
module sram_mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
`ifdef SRAM_ACCESS_CNT_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t        state;
  logic          op_wr;
  logic [16:0]   word;
  logic [31:0]   wdata;
  logic [CW-1:0] cnt;
  logic [15:0]   rd_lo;
  logic [15:0]   dq_out;
  logic          dq_oe;
  logic [16:0]   req_word;

  assign req_word  = 17'((address - BASE_ADDR) >> 2);
  assign SRAM_DQ   = dq_oe ? dq_out : 'z;
  assign ready     = ~(rd_en | wr_en) | (state == DONE);
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  // WE_N is low for every phase cycle except the last, so the strobe rises
  // while address and data are still held.
  function automatic logic we_level(input logic is_wr, input logic [CW-1:0] c);
    return !(is_wr && (32'(c) < WAIT_CYCLES));
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op_wr     <= 1'b0;
      word      <= '0;
      wdata     <= '0;
      cnt       <= '0;
      rd_lo     <= '0;
      read_data <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b0;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_en | wr_en) begin
            state     <= LO;
            op_wr     <= wr_en;
            word      <= req_word;
            wdata     <= write_data;
            cnt       <= '0;
            SRAM_ADDR <= {req_word, 1'b0};
            SRAM_WE_N <= we_level(wr_en, '0);
            SRAM_OE_N <= wr_en;
            dq_out    <= write_data[15:0];
            dq_oe     <= wr_en;
          end
        end
        LO: begin
          if (cnt == LAST) begin
            state     <= HI;
            cnt       <= '0;
            SRAM_ADDR <= {word, 1'b1};
            SRAM_WE_N <= we_level(op_wr, '0);
            dq_out    <= wdata[31:16];
            if (!op_wr) rd_lo <= SRAM_DQ;
          end else begin
            cnt       <= cnt + 1'b1;
            SRAM_WE_N <= we_level(op_wr, cnt + 1'b1);
          end
        end
        HI: begin
          if (cnt == LAST) begin
            state     <= DONE;
            cnt       <= '0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b0;
            dq_oe     <= 1'b0;
            if (!op_wr) read_data <= {SRAM_DQ, rd_lo};
          end else begin
            cnt       <= cnt + 1'b1;
            SRAM_WE_N <= we_level(op_wr, cnt + 1'b1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SRAM_ACCESS_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == DONE) begin
      if (op_wr && wr_count != '1) wr_count <= wr_count + 16'd1;
      if (!op_wr && rd_count != '1) rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Randomized bench for sram_mem_ctrl: a pin-level SRAM plus a word-level
// reference model that predicts ready, read_data and memory contents.
module tb_sram_mem_ctrl;
  localparam int unsigned W     = 1;
  localparam int          ACC   = 2 * W + 3;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
`ifdef SRAM_ACCESS_CNT_EN
  logic [15:0] rd_count, wr_count;
`endif

  sram_mem_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
    .SRAM_WE_N(sram_we_n), .SRAM_OE_N(sram_oe_n),
    .SRAM_CE_N(sram_ce_n), .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n)
`ifdef SRAM_ACCESS_CNT_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [15:0] seed_val(input int unsigned i);
    return 16'(i * 40503 + 12345);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pin-level asynchronous SRAM: drives the bus while OE_N=0 and WE_N=1.
  logic [15:0] sram [DEPTH];
  bit          sram_seeded = 1'b0;
  assign sram_dq = (!sram_oe_n && sram_we_n) ? sram[sram_addr[9:0]] : 'z;
  always @(posedge clk) begin
    if (!sram_seeded) begin
      for (int i = 0; i < int'(DEPTH); i++) sram[i] <= seed_val(i);
      sram_seeded <= 1'b1;
    end else if (!sram_we_n) begin
      sram[sram_addr[9:0]] <= sram_dq;
    end
  end

  // Reference model: age counts cycles since acceptance (-1 = idle).
  logic [15:0] mref [DEPTH];
  bit          mref_seeded = 1'b0;
  int          age = -1;
  bit          m_wr;
  int unsigned m_word;
  logic [31:0] m_data;
  logic [31:0] exp_rd = '0;
  int          m_rd_cnt = 0, m_wr_cnt = 0;

  always @(posedge clk or negedge rst) begin
    if (!mref_seeded) begin
      for (int i = 0; i < int'(DEPTH); i++) mref[i] = seed_val(i);
      mref_seeded = 1'b1;
    end
    if (!rst) begin
      if (age > 0 && m_wr) begin
        if (age >= 2)     mref[2*m_word]     = m_data[15:0];
        if (age >= W + 3) mref[2*m_word + 1] = m_data[31:16];
      end
      age = -1;
      exp_rd = '0;
      m_rd_cnt = 0;
      m_wr_cnt = 0;
    end else if (age < 0) begin
      if (rd_en | wr_en) begin
        age    = 1;
        m_wr   = wr_en;
        m_word = ((address - 32'd1024) >> 2) & 32'h1FFFF;
        m_data = write_data;
      end
    end else if (age == ACC) begin
      age = -1;
      if (m_wr) m_wr_cnt = (m_wr_cnt < 65535) ? m_wr_cnt + 1 : 65535;
      else      m_rd_cnt = (m_rd_cnt < 65535) ? m_rd_cnt + 1 : 65535;
    end else begin
      age++;
      if (age == ACC) begin
        if (m_wr) begin
          mref[2*m_word]     = m_data[15:0];
          mref[2*m_word + 1] = m_data[31:16];
        end else begin
          exp_rd = {mref[2*m_word + 1], mref[2*m_word]};
        end
      end
    end
  end

  bit checking = 1'b0;
  always @(negedge clk) begin
    if (checking) begin
      check("ready", 32'(ready), 32'(!(rd_en | wr_en) || age == ACC));
      check("read_data", read_data, exp_rd);
      check("tie_offs", 32'({sram_ce_n, sram_ub_n, sram_lb_n}), 32'd0);
      if (!sram_we_n) check("oe_during_write", 32'(sram_oe_n), 32'd1);
`ifdef SRAM_ACCESS_CNT_EN
      check("rd_count", 32'(rd_count), 32'(m_rd_cnt));
      check("wr_count", 32'(wr_count), 32'(m_wr_cnt));
`endif
    end
  end

  task automatic access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                        input int drop_after, output int low);
    bit done;
    done = 1'b0;
    low  = 0;
    @(posedge clk);
    #1;
    wr_en = w; rd_en = r; address = a; write_data = d;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (ready) done = 1'b1;
      else begin
        low++;
        if (drop_after > 0 && low == drop_after) begin
          @(posedge clk);
          #1;
          wr_en = 1'b0; rd_en = 1'b0;
          repeat (ACC + 1) @(posedge clk);
          low = -1;
          return;
        end
      end
    end
    if (!done) begin
      miscompares++;
      $display("FAIL access_timeout: ready never rose for addr %h", a);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    int low;
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_read_data", read_data, 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe_n", 32'(sram_oe_n), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    #1 rst = 1'b1;
    checking = 1'b1;

    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 0, low);
    check("t1_ready_low", 32'(low), 32'd5);
    check("t1_sram0", 32'(sram[0]), 32'h0000BEEF);
    check("t1_sram1", 32'(sram[1]), 32'h0000DEAD);

    access(1'b0, 1'b1, 32'd1024, 32'h0, 0, low);
    check("t2_read", read_data, 32'hDEADBEEF);

    access(1'b1, 1'b0, 32'd1028, 32'h12345678, 0, low);
    check("t3_sram2", 32'(sram[2]), 32'h00005678);
    check("t3_sram3", 32'(sram[3]), 32'h00001234);
    check("t3_sram0", 32'(sram[0]), 32'h0000BEEF);
    check("t3_sram1", 32'(sram[1]), 32'h0000DEAD);

    access(1'b1, 1'b1, 32'd1032, 32'hA5A50F0F, 0, low);
    check("t4_sram4", 32'(sram[4]), 32'h00000F0F);
    check("t4_sram5", 32'(sram[5]), 32'h0000A5A5);
    check("t4_read_held", read_data, 32'hDEADBEEF);

    access(1'b0, 1'b1, 32'd1029, 32'h0, 0, low);
    check("t2b_read", read_data, 32'h12345678);
`ifdef SRAM_ACCESS_CNT_EN
    check("t6_wr_count", 32'(wr_count), 32'd3);
    check("t6_rd_count", 32'(rd_count), 32'd2);
`endif

    // Reset in the first cycle of the high phase of a write.
    @(posedge clk);
    #1 wr_en = 1'b1; address = 32'd1036; write_data = 32'h3C3C9696;
    repeat (4) @(negedge clk);
    #1 rst = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    check("t5_we_n", 32'(sram_we_n), 32'd1);
    check("t5_ready", 32'(ready), 32'd1);
    #1 rst = 1'b1;
    check("t5_sram6", 32'(sram[6]), 32'h00009696);
    check("t5_sram7", 32'(sram[7]), 32'(seed_val(7)));
    access(1'b0, 1'b1, 32'd1036, 32'h0, 0, low);
    check("t5_read", read_data, {seed_val(7), 16'h9696});

    for (int n = 0; n < 200; n++) begin
      int unsigned op;
      int drop;
      op   = $urandom_range(0, 3);
      drop = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      access(op == 1 || op == 2, op != 1, 32'd1024 + 4 * $urandom_range(0, 255) + $urandom_range(0, 3),
             $urandom, drop, low);
      if (drop == 0) check("rand_ready_low", 32'(low), 32'(ACC - 1 + 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (2) @(posedge clk);
    checking = 1'b0;
    for (int i = 0; i < 512; i++) check("final_mem", 32'(sram[i]), 32'(mref[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
